// File: rtl/haar_pkg.sv
// ---------------------------------------------------------------------------
// haar_pkg
// Shared definitions for the integral-image window reader:
//   - default parameter values (tap width, address width, window size)
//   - the reader FSM state type
//   - a small helper that says whether a state is actively counting pixels
// ---------------------------------------------------------------------------
package haar_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_ADDR_WIDTH     = 10;
    localparam int DEF_INTEGRAL_WIDTH = 3;
    localparam int DEF_WINDOW_ROWS    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } iwr_state_e;

    // True in the two states where wen advances the position counters.
    function automatic logic state_is_busy(input iwr_state_e st);
        return (st == ST_FILL) || (st == ST_STREAM);
    endfunction

endpackage

// File: rtl/rect_sum_pipe.sv
// ---------------------------------------------------------------------------
// rect_sum_pipe
// Two-stage rectangle-sum arithmetic on integral-image corner taps:
//   stage 1: (br - bl) and (tr - tl)
//   stage 2: (br - bl) - (tr - tl)
// All arithmetic wraps modulo 2^DATA_WIDTH; no overflow indication.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset (flushes pipe)
//   tl, tr, bl, br     corner taps, sampled when in_valid is high
//   in_valid           taps qualifier
//   sum, out_valid     result and its qualifier, two cycles after in_valid
// ---------------------------------------------------------------------------
module rect_sum_pipe
    import haar_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] tl,
    input  logic [DATA_WIDTH-1:0] tr,
    input  logic [DATA_WIDTH-1:0] bl,
    input  logic [DATA_WIDTH-1:0] br,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  out_valid
);

    logic [DATA_WIDTH-1:0] diff_bot_q;
    logic [DATA_WIDTH-1:0] diff_top_q;
    logic                  v1_q;
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  v2_q;

    // Both pipeline stages; data registers only load when their stage is valid.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            diff_bot_q <= {DATA_WIDTH{1'b0}};
            diff_top_q <= {DATA_WIDTH{1'b0}};
            v1_q       <= 1'b0;
            sum_q      <= {DATA_WIDTH{1'b0}};
            v2_q       <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                diff_bot_q <= br - bl;
                diff_top_q <= tr - tl;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                sum_q <= diff_bot_q - diff_top_q;
            end
        end
    end

    assign sum       = sum_q;
    assign out_valid = v2_q;

endmodule

// File: rtl/integral_window_reader.sv
// ---------------------------------------------------------------------------
// integral_window_reader
// Walks a frame pixel by pixel on the wen strobe, and for every pixel where a
// full INTEGRAL_WIDTH x WINDOW_ROWS window fits above and to the left, turns
// the four corner integral taps into a rectangle sum (br - bl - tr + tl).
// Ports:
//   clk_os, reset_os           clock, synchronous active-high reset
//   i_start                    arm for a new frame (ignored unless IDLE)
//   i_frame_width/height       frame size, sampled on an accepted start
//   wen                        pixel-advance strobe
//   i_tl/i_tr/i_bl/i_br        corner taps for the current pixel
//   o_rect_sum, o_valid        result and qualifier, 2 cycles after the wen
//   o_col, o_row               bottom-right position of the result
//   o_frame_done               pulse aligned with the last pixel's result slot
//   o_busy                     high while in FILL or STREAM
// ---------------------------------------------------------------------------
module integral_window_reader
    import haar_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int INTEGRAL_WIDTH = DEF_INTEGRAL_WIDTH,
    parameter int WINDOW_ROWS    = DEF_WINDOW_ROWS
) (
    input  logic                  clk_os,
    input  logic                  reset_os,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_frame_width,
    input  logic [ADDR_WIDTH-1:0] i_frame_height,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] i_tl,
    input  logic [DATA_WIDTH-1:0] i_tr,
    input  logic [DATA_WIDTH-1:0] i_bl,
    input  logic [DATA_WIDTH-1:0] i_br,
    output logic [DATA_WIDTH-1:0] o_rect_sum,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_col,
    output logic [ADDR_WIDTH-1:0] o_row,
    output logic                  o_frame_done,
    output logic                  o_busy
);

    localparam logic [ADDR_WIDTH-1:0] ZERO     = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] COL_QUAL = ADDR_WIDTH'(INTEGRAL_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_QUAL = ADDR_WIDTH'(WINDOW_ROWS - 1);

    iwr_state_e            state_q;
    logic [ADDR_WIDTH-1:0] width_q;
    logic [ADDR_WIDTH-1:0] height_q;
    logic [ADDR_WIDTH-1:0] col_q;
    logic [ADDR_WIDTH-1:0] row_q;
    logic [ADDR_WIDTH-1:0] col_d;
    logic [ADDR_WIDTH-1:0] row_d;

    // Side-band that travels alongside the arithmetic pipeline.
    logic                  qual1_q;
    logic [ADDR_WIDTH-1:0] col1_q;
    logic [ADDR_WIDTH-1:0] row1_q;
    logic                  done1_q;
    logic [ADDR_WIDTH-1:0] o_col_q;
    logic [ADDR_WIDTH-1:0] o_row_q;
    logic                  o_frame_done_q;
    logic                  o_busy_q;

    logic adv_s;
    logic qual_s;
    logic frame_last_s;
    logic col_last_s;
    logic start_ok_s;

    // Position qualifiers are evaluated on the position *before* this wen.
    assign adv_s        = wen && state_is_busy(state_q);
    assign qual_s       = (col_q >= COL_QUAL) && (row_q >= ROW_QUAL);
    assign col_last_s   = (col_q == (width_q - ONE));
    assign frame_last_s = col_last_s && (row_q == (height_q - ONE));
    assign start_ok_s   = i_start && (i_frame_width != ZERO) && (i_frame_height != ZERO);

    // Raster-order next position: wrap the column at the row end.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (col_last_s) begin
            col_d = ZERO;
            row_d = row_q + ONE;
        end else begin
            col_d = col_q + ONE;
            row_d = row_q;
        end
    end

    // Reader FSM, position counters and the registered side-band outputs.
    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            state_q        <= ST_IDLE;
            width_q        <= ZERO;
            height_q       <= ZERO;
            col_q          <= ZERO;
            row_q          <= ZERO;
            qual1_q        <= 1'b0;
            col1_q         <= ZERO;
            row1_q         <= ZERO;
            done1_q        <= 1'b0;
            o_col_q        <= ZERO;
            o_row_q        <= ZERO;
            o_frame_done_q <= 1'b0;
            o_busy_q       <= 1'b0;
        end else begin
            qual1_q <= adv_s && qual_s;
            if (adv_s) begin
                col1_q <= col_q;
                row1_q <= row_q;
            end
            done1_q        <= adv_s && frame_last_s;
            o_frame_done_q <= done1_q;
            if (qual1_q) begin
                o_col_q <= col1_q;
                o_row_q <= row1_q;
            end

            case (state_q)
                ST_IDLE: begin
                    // A wen in the same cycle as the start is not a pixel.
                    if (start_ok_s) begin
                        width_q  <= i_frame_width;
                        height_q <= i_frame_height;
                        col_q    <= ZERO;
                        row_q    <= ZERO;
                        state_q  <= ST_FILL;
                        o_busy_q <= 1'b1;
                    end
                end
                ST_FILL, ST_STREAM: begin
                    if (wen) begin
                        col_q <= col_d;
                        row_q <= row_d;
                        if (frame_last_s) begin
                            state_q  <= ST_DONE;
                            o_busy_q <= 1'b0;
                        end else if (qual_s) begin
                            state_q <= ST_STREAM;
                        end
                    end
                end
                ST_DONE: begin
                    // Leave only once the frame-done pulse has been presented.
                    if (o_frame_done_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    o_busy_q <= 1'b0;
                end
            endcase
        end
    end

    rect_sum_pipe #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pipe (
        .clk_i     (clk_os),
        .reset_i   (reset_os),
        .tl        (i_tl),
        .tr        (i_tr),
        .bl        (i_bl),
        .br        (i_br),
        .in_valid  (adv_s && qual_s),
        .sum       (o_rect_sum),
        .out_valid (o_valid)
    );

    assign o_col        = o_col_q;
    assign o_row        = o_row_q;
    assign o_frame_done = o_frame_done_q;
    assign o_busy       = o_busy_q;

endmodule

// File: tb/tb_integral_window_reader.sv
// ---------------------------------------------------------------------------
// tb_integral_window_reader
// Directed scenarios with hand-computed expectations. A tick task advances one
// clock, samples outputs 1 ns after the edge and logs every o_valid result and
// every o_frame_done pulse; each scenario task then checks the logs inline.
// ---------------------------------------------------------------------------
module tb_integral_window_reader;

    logic       clk_os = 1'b0;
    logic       reset_os;
    logic       i_start;
    logic [9:0] i_frame_width;
    logic [9:0] i_frame_height;
    logic       wen;
    logic [7:0] i_tl, i_tr, i_bl, i_br;
    logic [7:0] o_rect_sum;
    logic       o_valid;
    logic [9:0] o_col, o_row;
    logic       o_frame_done;
    logic       o_busy;

    integral_window_reader dut (
        .clk_os         (clk_os),
        .reset_os       (reset_os),
        .i_start        (i_start),
        .i_frame_width  (i_frame_width),
        .i_frame_height (i_frame_height),
        .wen            (wen),
        .i_tl           (i_tl),
        .i_tr           (i_tr),
        .i_bl           (i_bl),
        .i_br           (i_br),
        .o_rect_sum     (o_rect_sum),
        .o_valid        (o_valid),
        .o_col          (o_col),
        .o_row          (o_row),
        .o_frame_done   (o_frame_done),
        .o_busy         (o_busy)
    );

    always #5 clk_os = ~clk_os;

    typedef struct {
        int cyc;
        int col;
        int row;
        int sum;
        bit done;
    } res_t;

    res_t rq[$];
    int   done_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic tick();
        res_t r;
        @(posedge clk_os);
        #1;
        cyc = cyc + 1;
        if (o_valid === 1'b1) begin
            r.cyc  = cyc;
            r.col  = int'(o_col);
            r.row  = int'(o_row);
            r.sum  = int'(o_rect_sum);
            r.done = o_frame_done;
            rq.push_back(r);
        end
        if (o_frame_done === 1'b1) done_q.push_back(cyc);
    endtask

    task automatic set_taps(input int tl, input int tr, input int bl, input int br);
        i_tl = 8'(tl); i_tr = 8'(tr); i_bl = 8'(bl); i_br = 8'(br);
    endtask

    task automatic apply_reset();
        reset_os = 1'b1; i_start = 1'b0; wen = 1'b0;
        i_frame_width = 10'd0; i_frame_height = 10'd0;
        set_taps(0, 0, 0, 0);
        tick(); tick();
        reset_os = 1'b0;
        rq.delete(); done_q.delete();
    endtask

    task automatic do_start(input int w, input int h);
        i_frame_width = 10'(w); i_frame_height = 10'(h);
        i_start = 1'b1; tick(); i_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_os = 1'b1; i_start = 1'b1; wen = 1'b1;
        i_frame_width = 10'd4; i_frame_height = 10'd3;
        set_taps(1, 3, 4, 10);
        tick(); tick();
        n_tests++; if (o_rect_sum !== 8'd0) begin n_fail++; $display("FAIL reset_sum got %0d want 0", o_rect_sum); end
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
        n_tests++; if (o_col !== 10'd0) begin n_fail++; $display("FAIL reset_col got %0d want 0", o_col); end
        n_tests++; if (o_row !== 10'd0) begin n_fail++; $display("FAIL reset_row got %0d want 0", o_row); end
        n_tests++; if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", o_frame_done); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0 (reset over start)", o_busy); end
        apply_reset();
    endtask

    task automatic test_basic();
        int wc[12];
        apply_reset();
        do_start(4, 3);
        n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", o_busy); end
        set_taps(1, 3, 4, 10);
        for (int k = 0; k < 12; k++) begin wen = 1'b1; tick(); wc[k] = cyc; end
        wen = 1'b0;
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", o_busy); end
        repeat (4) tick();
        n_tests++; if (rq.size() != 2) begin n_fail++; $display("FAIL basic_count got %0d want 2", rq.size()); end
        if (rq.size() == 2) begin
            for (int i = 0; i < 2; i++) begin
                n_tests++; if (rq[i].sum != 4) begin n_fail++; $display("FAIL basic_sum%0d got %0d want 4", i, rq[i].sum); end
                n_tests++; if (rq[i].col != 2 + i || rq[i].row != 2) begin n_fail++; $display("FAIL basic_pos%0d got (%0d,%0d) want (%0d,2)", i, rq[i].col, rq[i].row, 2 + i); end
                n_tests++; if (rq[i].cyc != wc[10 + i] + 1) begin n_fail++; $display("FAIL basic_lat%0d got cyc %0d want %0d", i, rq[i].cyc, wc[10 + i] + 1); end
            end
            n_tests++; if (rq[1].done != 1'b1 || rq[0].done != 1'b0) begin n_fail++; $display("FAIL basic_done_align got %b%b want 01", rq[0].done, rq[1].done); end
        end
        n_tests++; if (done_q.size() != 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_q.size()); end
    endtask

    task automatic test_wrap();
        apply_reset();
        do_start(3, 3);
        set_taps(0, 200, 100, 50);
        for (int k = 0; k < 9; k++) begin wen = 1'b1; tick(); end
        wen = 1'b0;
        repeat (3) tick();
        n_tests++; if (rq.size() != 1) begin n_fail++; $display("FAIL wrap_count got %0d want 1", rq.size()); end
        if (rq.size() == 1) begin
            n_tests++; if (rq[0].sum != 6) begin n_fail++; $display("FAIL wrap_sum got %0d want 6", rq[0].sum); end
        end
    endtask

    task automatic test_undersized();
        int last_wen;
        apply_reset();
        do_start(2, 5);
        set_taps(1, 3, 4, 10);
        for (int k = 0; k < 10; k++) begin wen = 1'b1; tick(); end
        last_wen = cyc;
        wen = 1'b0;
        repeat (4) tick();
        n_tests++; if (rq.size() != 0) begin n_fail++; $display("FAIL under_valid got %0d results want 0", rq.size()); end
        n_tests++; if (done_q.size() != 1) begin n_fail++; $display("FAIL under_done_count got %0d want 1", done_q.size()); end
        if (done_q.size() == 1) begin
            n_tests++; if (done_q[0] != last_wen + 1) begin n_fail++; $display("FAIL under_done_lat got cyc %0d want %0d", done_q[0], last_wen + 1); end
        end
        do_start(4, 3);
        n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL under_idle got busy %b want 1 after restart", o_busy); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_start(4, 3);
        set_taps(1, 3, 4, 10);
        for (int k = 0; k < 11; k++) begin wen = 1'b1; tick(); end
        wen = 1'b0;
        reset_os = 1'b1; tick(); reset_os = 1'b0;
        n_tests++; if ({o_rect_sum, o_valid, o_col, o_row, o_frame_done, o_busy} !== 31'd0) begin
            n_fail++; $display("FAIL midreset_outs got sum=%0d v=%b col=%0d row=%0d d=%b b=%b want all 0", o_rect_sum, o_valid, o_col, o_row, o_frame_done, o_busy);
        end
        repeat (4) tick();
        n_tests++; if (rq.size() != 0 || done_q.size() != 0) begin n_fail++; $display("FAIL midreset_flush got %0d results %0d done want 0 0", rq.size(), done_q.size()); end
        do_start(4, 3);
        n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midreset_idle got busy %b want 1 after restart", o_busy); end
    endtask

    task automatic test_gapped();
        int wc[12];
        apply_reset();
        i_frame_width = 10'd4; i_frame_height = 10'd3;
        set_taps(9, 9, 9, 90);
        i_start = 1'b1; wen = 1'b1; tick();
        i_start = 1'b0; wen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            set_taps(255, 255, 255, 255);
            wen = 1'b0; tick(); tick();
            set_taps(k, 2 * k, 3 * k, 7 * k);
            wen = 1'b1; tick(); wc[k] = cyc;
        end
        wen = 1'b0;
        repeat (4) tick();
        n_tests++; if (rq.size() != 2) begin n_fail++; $display("FAIL gap_count got %0d want 2", rq.size()); end
        if (rq.size() == 2) begin
            n_tests++; if (rq[0].sum != 30 || rq[0].col != 2 || rq[0].row != 2) begin n_fail++; $display("FAIL gap_res0 got %0d@(%0d,%0d) want 30@(2,2)", rq[0].sum, rq[0].col, rq[0].row); end
            n_tests++; if (rq[1].sum != 33 || rq[1].col != 3 || rq[1].row != 2) begin n_fail++; $display("FAIL gap_res1 got %0d@(%0d,%0d) want 33@(3,2)", rq[1].sum, rq[1].col, rq[1].row); end
            n_tests++; if (rq[0].cyc != wc[10] + 1 || rq[1].cyc != wc[11] + 1) begin n_fail++; $display("FAIL gap_lat got %0d,%0d want %0d,%0d", rq[0].cyc, rq[1].cyc, wc[10] + 1, wc[11] + 1); end
            n_tests++; if (rq[1].done != 1'b1) begin n_fail++; $display("FAIL gap_done got %b want 1", rq[1].done); end
        end
    endtask

    task automatic test_invalid_start();
        apply_reset();
        do_start(0, 3);
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL inv_w0 got busy %b want 0", o_busy); end
        do_start(4, 0);
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL inv_h0 got busy %b want 0", o_busy); end
        do_start(4, 3);
        set_taps(1, 3, 4, 10);
        for (int k = 0; k < 11; k++) begin wen = 1'b1; tick(); end
        wen = 1'b0;
        do_start(2, 2);
        n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL inv_stream_busy got %b want 1", o_busy); end
        wen = 1'b1; tick(); wen = 1'b0;
        repeat (4) tick();
        n_tests++; if (rq.size() != 2) begin n_fail++; $display("FAIL inv_count got %0d want 2", rq.size()); end
        if (rq.size() == 2) begin
            n_tests++; if (rq[1].col != 3 || rq[1].row != 2 || rq[1].done != 1'b1) begin n_fail++; $display("FAIL inv_last got (%0d,%0d) done=%b want (3,2) done=1", rq[1].col, rq[1].row, rq[1].done); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_undersized();
        test_reset_mid();
        test_gapped();
        test_invalid_start();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
